// File: rtl/wca_lime_bb_emu.sv
// Lime-side baseband bus emulator: ADC serialiser fed from a small sample FIFO,
// and a DAC deserialiser that locks to the interleaved I/Q word stream.
module wca_lime_bb_emu #(
   parameter int FIFO_DEPTH   = 4,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    rf_rxen,
   input  logic                    rf_txen,
   input  logic [23:0]             src_iq,
   input  logic                    src_valid,
   output logic                    src_ready,
   output logic [11:0]             adc_data,
   output logic                    adc_iqsel,
   output logic                    adc_underflow,
   input  logic [11:0]             dac_data,
   input  logic                    dac_iqsel,
   output logic [23:0]             snk_iq,
   output logic                    snk_strobe,
   output logic                    dac_locked,
   output logic [ERRCNT_WIDTH-1:0] sync_err_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // ---------------- sample FIFO ----------------
   logic [23:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic          src_ready_reg;
   logic          push, pop, fifo_empty;

   logic          phase_q_reg;
   logic [11:0]   q_hold_reg;
   logic [11:0]   adc_data_reg;
   logic          adc_iqsel_reg;
   logic          adc_underflow_reg;

   assign fifo_empty = (count_reg == '0);
   assign push       = src_valid & src_ready_reg;
   assign pop        = rf_rxen & ~phase_q_reg & ~fifo_empty;
   assign count_next = count_reg + CW'(push) - CW'(pop);
   assign src_ready  = src_ready_reg;

   always_ff @(posedge clock) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= src_iq;
   end

   // src_ready is registered from the post-update occupancy, so a full FIFO
   // refuses a push even in the cycle a pop frees a slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         src_ready_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg     <= count_next;
         src_ready_reg <= (count_next != CW'(FIFO_DEPTH));
      end
   end

   // ---------------- ADC serialiser ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q_reg       <= 1'b0;
         q_hold_reg        <= '0;
         adc_data_reg      <= '0;
         adc_iqsel_reg     <= 1'b0;
         adc_underflow_reg <= 1'b0;
      end else if (!rf_rxen) begin
         phase_q_reg   <= 1'b0;
         adc_data_reg  <= '0;
         adc_iqsel_reg <= 1'b0;
      end else if (!phase_q_reg) begin
         phase_q_reg   <= 1'b1;
         adc_iqsel_reg <= 1'b1;
         if (!fifo_empty) begin
            adc_data_reg <= fifo_mem[rd_ptr_reg][11:0];
            q_hold_reg   <= fifo_mem[rd_ptr_reg][23:12];
         end else begin
            adc_data_reg      <= '0;
            q_hold_reg        <= '0;
            adc_underflow_reg <= 1'b1;
         end
      end else begin
         phase_q_reg   <= 1'b0;
         adc_data_reg  <= q_hold_reg;
         adc_iqsel_reg <= 1'b0;
      end
   end

   assign adc_data      = adc_data_reg;
   assign adc_iqsel     = adc_iqsel_reg;
   assign adc_underflow = adc_underflow_reg;

   // ---------------- DAC deserialiser ----------------
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} dac_state_t;

   dac_state_t              state_reg, state_next;
   logic                    expect_reg, expect_next;
   logic                    prev_sel_reg, prev_sel_next;
   logic [11:0]             i_reg, i_next;
   logic [23:0]             snk_iq_reg, snk_iq_next;
   logic                    snk_strobe_reg, snk_strobe_next;
   logic [ERRCNT_WIDTH-1:0] err_reg, err_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= HUNT;
         expect_reg     <= 1'b0;
         prev_sel_reg   <= 1'b0;
         i_reg          <= '0;
         snk_iq_reg     <= '0;
         snk_strobe_reg <= 1'b0;
         err_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         expect_reg     <= expect_next;
         prev_sel_reg   <= prev_sel_next;
         i_reg          <= i_next;
         snk_iq_reg     <= snk_iq_next;
         snk_strobe_reg <= snk_strobe_next;
         err_reg        <= err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      expect_next     = expect_reg;
      prev_sel_next   = prev_sel_reg;
      i_next          = i_reg;
      snk_iq_next     = snk_iq_reg;
      snk_strobe_next = 1'b0;
      err_next        = err_reg;
      if (!rf_txen) begin
         state_next    = HUNT;
         prev_sel_next = 1'b0;
      end else begin
         prev_sel_next = dac_iqsel;
         case (state_reg)
            HUNT: begin
               // Only a fresh 0->1 edge marks a trustworthy I word.
               if (dac_iqsel && !prev_sel_reg) begin
                  i_next      = dac_data;
                  expect_next = 1'b0;
                  state_next  = LOCKED;
               end
            end
            LOCKED: begin
               if (dac_iqsel == expect_reg) begin
                  if (!expect_reg) begin
                     snk_iq_next     = {dac_data, i_reg};
                     snk_strobe_next = 1'b1;
                     expect_next     = 1'b1;
                  end else begin
                     i_next      = dac_data;
                     expect_next = 1'b0;
                  end
               end else begin
                  state_next = HUNT;
                  if (err_reg != '1)
                     err_next = err_reg + ERRCNT_WIDTH'(1);
               end
            end
            default: state_next = HUNT;
         endcase
      end
   end

   assign snk_iq         = snk_iq_reg;
   assign snk_strobe     = snk_strobe_reg;
   assign dac_locked     = (state_reg == LOCKED);
   assign sync_err_count = err_reg;

endmodule

// File: tb/tb_wca_lime_bb_emu.sv
// Self-checking bench for wca_lime_bb_emu: directed bus patterns plus randomized
// FIFO/ADC, DAC resync and registered loopback runs against queue-based models.
module tb_wca_lime_bb_emu;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rf_rxen = 1'b0;
   logic        rf_txen = 1'b0;
   logic [23:0] src_iq = '0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [11:0] adc_data;
   logic        adc_iqsel;
   logic        adc_underflow;
   logic [11:0] dac_data = '0;
   logic        dac_iqsel = 1'b0;
   logic [23:0] snk_iq;
   logic        snk_strobe;
   logic        dac_locked;
   logic [7:0]  sync_err_count;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   wca_lime_bb_emu #(.FIFO_DEPTH(DEPTH), .ERRCNT_WIDTH(8)) dut (
      .clock(clock), .reset(reset), .rf_rxen(rf_rxen), .rf_txen(rf_txen),
      .src_iq(src_iq), .src_valid(src_valid), .src_ready(src_ready),
      .adc_data(adc_data), .adc_iqsel(adc_iqsel), .adc_underflow(adc_underflow),
      .dac_data(dac_data), .dac_iqsel(dac_iqsel), .snk_iq(snk_iq),
      .snk_strobe(snk_strobe), .dac_locked(dac_locked),
      .sync_err_count(sync_err_count)
   );

   always #5 clock = ~clock;

   localparam logic [12:0] ADC_EXP [6] = '{
      {1'b1, 12'hF56}, {1'b0, 12'h00A}, {1'b1, 12'h456},
      {1'b0, 12'h123}, {1'b1, 12'h000}, {1'b0, 12'h000}};
   localparam logic ADC_UF [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   task automatic tick();
      @(posedge clock);
      #1;
      cycle++;
   endtask

   task automatic do_reset();
      reset = 1'b1; rf_rxen = 1'b0; rf_txen = 1'b0; src_valid = 1'b0;
      dac_iqsel = 1'b0; dac_data = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic push(input logic [23:0] v);
      src_iq = v; src_valid = 1'b1;
      tick();
      src_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if ({src_ready, adc_data, adc_iqsel, adc_underflow, snk_iq, snk_strobe,
           dac_locked, sync_err_count} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got ready=%b adc=%h/%b uf=%b snk=%h/%b lk=%b err=%0d, want all 0",
                  src_ready, adc_data, adc_iqsel, adc_underflow, snk_iq, snk_strobe, dac_locked, sync_err_count);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (src_ready !== 1'b1 || dac_locked !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: ready=%b locked=%b, want 1/0", src_ready, dac_locked);
      end
      $display("tb: test_reset done");
   endtask

   task automatic test_adc_basic();
      do_reset();
      push(24'h00AF56);
      push(24'h123456);
      rf_rxen = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({adc_iqsel, adc_data} !== ADC_EXP[i] || adc_underflow !== ADC_UF[i]) begin
            failures++;
            $display("FAIL adc_basic[%0d]: got %h/%b uf=%b, want %h/%b uf=%b", i,
                     adc_data, adc_iqsel, adc_underflow, ADC_EXP[i][11:0], ADC_EXP[i][12], ADC_UF[i]);
         end
      end
      rf_rxen = 1'b0;
      tick();
      checks++;
      if ({adc_iqsel, adc_data} !== 13'h0 || adc_underflow !== 1'b1) begin
         failures++;
         $display("FAIL adc_disable: got %h/%b uf=%b, want 000/0 uf=1", adc_data, adc_iqsel, adc_underflow);
      end
      $display("tb: test_adc_basic done");
   endtask

   task automatic test_fifo_full();
      logic [23:0] q[$];
      logic [23:0] s;
      logic [12:0] exp_w;
      logic [11:0] hold;
      logic        phase_m, uf_m, acc;
      do_reset();
      src_valid = 1'b1;
      src_iq = 24'($urandom);
      for (int c = 0; c < 6; c++) begin
         acc = (q.size() < DEPTH);
         tick();
         if (acc) begin
            q.push_back(src_iq);
            src_iq = 24'($urandom);
         end
         checks++;
         if (src_ready !== (q.size() < DEPTH)) begin
            failures++;
            $display("FAIL fill_ready[%0d]: got %b, want %b", c, src_ready, q.size() < DEPTH);
         end
      end
      rf_rxen = 1'b1;
      phase_m = 1'b0; uf_m = 1'b0; hold = '0;
      for (int c = 0; c < 16; c++) begin
         acc = src_valid && (q.size() < DEPTH);
         if (!phase_m) begin
            if (q.size() > 0) begin
               s = q.pop_front();
               exp_w = {1'b1, s[11:0]};
               hold = s[23:12];
            end else begin
               exp_w = {1'b1, 12'h000};
               hold = '0;
               uf_m = 1'b1;
            end
         end else begin
            exp_w = {1'b0, hold};
         end
         phase_m = ~phase_m;
         if (acc)
            q.push_back(src_iq);
         tick();
         if (acc)
            src_valid = 1'b0;
         checks++;
         if ({adc_iqsel, adc_data} !== exp_w || adc_underflow !== uf_m ||
             src_ready !== (q.size() < DEPTH)) begin
            failures++;
            $display("FAIL drain[%0d]: got %h/%b uf=%b rdy=%b, want %h/%b uf=%b rdy=%b", c,
                     adc_data, adc_iqsel, adc_underflow, src_ready, exp_w[11:0], exp_w[12], uf_m, q.size() < DEPTH);
         end
      end
      rf_rxen = 1'b0;
      $display("tb: test_fifo_full done");
   endtask

   task automatic test_dac_basic();
      logic        sel_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [11:0] dat_t [5] = '{12'h000, 12'h100, 12'hF00, 12'h001, 12'h002};
      logic        stb_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        lck_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [23:0] iq_t  [5] = '{24'h0, 24'h0, 24'hF00100, 24'hF00100, 24'h002001};
      do_reset();
      rf_txen = 1'b1;
      dat_t[0] = 12'($urandom);
      for (int i = 0; i < 5; i++) begin
         dac_iqsel = sel_t[i]; dac_data = dat_t[i];
         tick();
         checks++;
         if (snk_strobe !== stb_t[i] || dac_locked !== lck_t[i] || snk_iq !== iq_t[i]) begin
            failures++;
            $display("FAIL dac_basic[%0d]: got stb=%b lk=%b iq=%h, want stb=%b lk=%b iq=%h", i,
                     snk_strobe, dac_locked, snk_iq, stb_t[i], lck_t[i], iq_t[i]);
         end
      end
      $display("tb: test_dac_basic done");
   endtask

   // Continues from the locked state left by test_dac_basic (next word is I).
   task automatic test_dac_resync();
      logic [11:0] iv, qv;
      logic [23:0] last_iq;
      last_iq = 24'h002001;
      for (int p = 0; p < 13; p++) begin
         iv = 12'($urandom); qv = 12'($urandom);
         if (p == 12) begin
            // second I in a row: lock loss
            dac_iqsel = 1'b1; dac_data = iv;
            tick();
            dac_iqsel = 1'b1; dac_data = qv;
            tick();
            checks++;
            if (sync_err_count !== 8'd1 || dac_locked !== 1'b0 || snk_strobe !== 1'b0) begin
               failures++;
               $display("FAIL lock_loss: got err=%0d lk=%b stb=%b, want 1/0/0", sync_err_count, dac_locked, snk_strobe);
            end
            dac_iqsel = 1'b0; dac_data = qv;
            tick();
            checks++;
            if (dac_locked !== 1'b0 || snk_strobe !== 1'b0 || snk_iq !== last_iq) begin
               failures++;
               $display("FAIL hunt_q: got lk=%b stb=%b iq=%h, want 0/0/%h", dac_locked, snk_strobe, snk_iq, last_iq);
            end
            iv = 12'($urandom); qv = 12'($urandom);
         end
         dac_iqsel = 1'b1; dac_data = iv;
         tick();
         checks++;
         if (snk_strobe !== 1'b0 || dac_locked !== 1'b1) begin
            failures++;
            $display("FAIL resync_i[%0d]: got stb=%b lk=%b, want 0/1", p, snk_strobe, dac_locked);
         end
         dac_iqsel = 1'b0; dac_data = qv;
         tick();
         last_iq = {qv, iv};
         checks++;
         if (snk_strobe !== 1'b1 || snk_iq !== last_iq) begin
            failures++;
            $display("FAIL resync_q[%0d]: got stb=%b iq=%h, want 1/%h", p, snk_strobe, snk_iq, last_iq);
         end
      end
      $display("tb: test_dac_resync done err=%0d", sync_err_count);
   endtask

   task automatic test_err_saturation();
      int err_m;
      do_reset();
      rf_txen = 1'b1;
      err_m = 0;
      for (int n = 0; n < 300; n++) begin
         dac_iqsel = 1'b0; dac_data = 12'($urandom); tick();
         dac_iqsel = 1'b1; dac_data = 12'($urandom); tick();
         dac_iqsel = 1'b1; dac_data = 12'($urandom); tick();
         err_m = (err_m == 255) ? 255 : err_m + 1;
         checks++;
         if (sync_err_count !== 8'(err_m) || dac_locked !== 1'b0) begin
            failures++;
            $display("FAIL err_count[%0d]: got %0d lk=%b, want %0d lk=0", n, sync_err_count, dac_locked, err_m);
         end
      end
      checks++;
      if (sync_err_count !== 8'd255) begin
         failures++;
         $display("FAIL err_saturate: got %0d, want 255", sync_err_count);
      end
      $display("tb: test_err_saturation done");
   endtask

   task automatic test_reset_mid_pair();
      do_reset();
      push(24'($urandom));
      push(24'($urandom));
      rf_txen = 1'b1;
      dac_iqsel = 1'b1; tick();
      dac_iqsel = 1'b1; tick();
      dac_iqsel = 1'b0; tick();
      dac_iqsel = 1'b1; dac_data = 12'($urandom);
      rf_rxen = 1'b1;
      tick();
      dac_iqsel = 1'b0; dac_data = 12'($urandom);
      reset = 1'b1;
      tick();
      checks++;
      if ({src_ready, adc_data, adc_iqsel, adc_underflow, snk_iq, snk_strobe,
           dac_locked, sync_err_count} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs: got ready=%b adc=%h/%b uf=%b snk=%h/%b lk=%b err=%0d, want all 0",
                  src_ready, adc_data, adc_iqsel, adc_underflow, snk_iq, snk_strobe, dac_locked, sync_err_count);
      end
      reset = 1'b0; rf_rxen = 1'b0;
      tick();
      checks++;
      if (snk_strobe !== 1'b0 || dac_locked !== 1'b0) begin
         failures++;
         $display("FAIL midreset_partial: got stb=%b lk=%b, want 0/0", snk_strobe, dac_locked);
      end
      rf_rxen = 1'b1;
      tick();
      checks++;
      if ({adc_iqsel, adc_data} !== {1'b1, 12'h000} || adc_underflow !== 1'b1) begin
         failures++;
         $display("FAIL midreset_flush: got %h/%b uf=%b, want 000/1 uf=1", adc_data, adc_iqsel, adc_underflow);
      end
      rf_rxen = 1'b0; rf_txen = 1'b0;
      $display("tb: test_reset_mid_pair done");
   endtask

   task automatic test_loopback();
      logic [23:0] q[$];
      logic [23:0] v, want;
      logic [11:0] lb_data;
      logic        lb_sel, acc;
      int          first_i, first_s, strobes;
      do_reset();
      rf_txen = 1'b1;
      for (int i = 0; i < 2; i++) begin
         v = 24'($urandom);
         q.push_back(v);
         push(v);
      end
      rf_rxen = 1'b1; src_valid = 1'b1; src_iq = 24'($urandom);
      lb_data = '0; lb_sel = 1'b0;
      first_i = -1; first_s = -1; strobes = 0;
      for (int c = 0; c < 80; c++) begin
         acc = src_valid && src_ready;
         tick();
         if (acc) begin
            q.push_back(src_iq);
            src_iq = 24'($urandom);
         end
         dac_data = lb_data; dac_iqsel = lb_sel;
         lb_data = adc_data; lb_sel = adc_iqsel;
         if (adc_iqsel && first_i < 0)
            first_i = cycle;
         if (snk_strobe) begin
            strobes++;
            want = (q.size() > 0) ? q.pop_front() : 24'hxxxxxx;
            $display("tb: loopback sample %0d got %h want %h", strobes, snk_iq, want);
            checks++;
            if (snk_iq !== want) begin
               failures++;
               $display("FAIL loopback[%0d]: got %h, want %h", strobes, snk_iq, want);
            end
            if (first_s < 0) begin
               first_s = cycle;
               checks++;
               if (first_s - first_i !== 3) begin
                  failures++;
                  $display("FAIL loopback_latency: got %0d clocks, want 3", first_s - first_i);
               end
            end
         end
      end
      src_valid = 1'b0;
      checks++;
      if (strobes < 30 || adc_underflow !== 1'b0) begin
         failures++;
         $display("FAIL loopback_count: got %0d strobes uf=%b, want >=30 uf=0", strobes, adc_underflow);
      end
      rf_rxen = 1'b0; rf_txen = 1'b0;
      $display("tb: test_loopback done");
   endtask

   initial begin
      test_reset();
      test_adc_basic();
      test_fifo_full();
      test_dac_basic();
      test_dac_resync();
      test_err_saturation();
      test_reset_mid_pair();
      test_loopback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wca_lime_bb_emu.md
Name: wca_lime_bb_emu

Overview:
- Behavioural emulator of the Lime chip side of the 12-bit interleaved baseband bus. It is the far end of the FPGA Lime interface, used for loopback benches and for hardware self-test without an RF chip.
- ADC side: serialises 24-bit I/Q samples from a small FIFO onto a 12-bit bus with an IQ-select line.
- DAC side: hunts for and locks to the incoming interleaved 12-bit stream, rebuilds 24-bit samples, and counts framing errors.

Parameters:
- FIFO_DEPTH, 4: ADC sample FIFO depth in 24-bit entries; power of two, minimum 2.
- ERRCNT_WIDTH, 8: width of the saturating DAC framing-error counter.

Ports:
- clock  in  1  single block clock; one 12-bit word per edge on both buses.
- reset  in  1  synchronous, active-high.
- rf_rxen  in  1  ADC enable from the interface control register.
- rf_txen  in  1  DAC enable from the interface control register.
- src_iq  in  24  sample to emit; I = [11:0], Q = [23:12].
- src_valid  in  1  src_iq is valid.
- src_ready  out  1  FIFO can accept a sample.
- adc_data  out  12  emulated ADC data word.
- adc_iqsel  out  1  1 = I word, 0 = Q word.
- adc_underflow  out  1  sticky: FIFO was empty at the start of a sample pair.
- dac_data  in  12  DAC word from the interface.
- dac_iqsel  in  1  DAC IQ select from the interface.
- snk_iq  out  24  reconstructed sample, {Q, I}.
- snk_strobe  out  1  one-clock pulse; snk_iq valid.
- dac_locked  out  1  DAC deserialiser is in LOCKED.
- sync_err_count  out  ERRCNT_WIDTH  saturating count of lock losses.

Behaviour:
- Reset values: all outputs 0; FIFO empty; ADC phase = I; DAC state = HUNT.
- Reset is honoured mid-operation: it flushes the FIFO, discards any partial DAC sample, and clears the counter and the sticky flag.
- FIFO:
  - Push when src_valid & src_ready.
  - src_ready = ~full; it depends only on registered state and has no same-cycle bypass.
  - Simultaneous push and pop when full: the pop proceeds and the push is refused because src_ready is low.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- ADC serialiser (all outputs registered):
  - rf_rxen=0: adc_data<=0, adc_iqsel<=0, phase<=I, no pop.
  - rf_rxen=1, phase I, FIFO non-empty: pop; adc_data<=entry[11:0]; adc_iqsel<=1; hold entry[23:12] in a Q register; phase<=Q.
  - rf_rxen=1, phase I, FIFO empty: adc_data<=0, adc_iqsel<=1, Q register<=0, adc_underflow<=1, phase<=Q.
  - Phase Q: adc_data<=Q register, adc_iqsel<=0, phase<=I.
  - Deasserting rf_rxen mid-pair abandons the Q word; the popped sample is lost.
  - Result: first I word appears 1 clock after rf_rxen is first sampled high; one sample is consumed per 2 clocks.
- DAC deserialiser, states HUNT and LOCKED. prev_sel is the registered previous dac_iqsel.
  - rf_txen=0: state<=HUNT, no strobe, no error count, prev_sel<=0.
  - HUNT:
    - On dac_iqsel=1 with prev_sel=0: capture I<=dac_data, expect<=0, state<=LOCKED.
    - Otherwise remain in HUNT.
  - LOCKED, dac_iqsel==expect:
    - expect=0: snk_iq<={dac_data, I}; snk_strobe<=1 on the next edge; expect<=1.
    - expect=1: I<=dac_data; expect<=0.
  - LOCKED, dac_iqsel!=expect: state<=HUNT, no strobe, sync_err_count+=1 (saturates at all-ones).
    - The mismatching word is then evaluated as a HUNT word on the following cycles. A 0->1 edge relock needs prev_sel=0.
  - snk_strobe is high in the cycle after the Q word is sampled; snk_iq holds its value until the next strobe.
  - dac_locked = (state==LOCKED).

Test Plan:
- Push 0x00A_F56 then 0x123_456 with rf_rxen=1 -> adc_data/adc_iqsel = F56/1, 00A/0, 456/1, 123/0 on consecutive clocks; adc_underflow stays 0 while two samples are queued.
- Push FIFO_DEPTH+1 samples with rf_rxen=0 -> src_ready drops after 4 pushes and the 5th is held. Enabling rf_rxen drains the FIFO in order with no loss; when it runs dry the output is 000/1, 000/0 and adc_underflow=1.
- Drive dac_iqsel 0,1,0,1,0 with dac_data x, 0x100, 0xF00, 0x001, 0x002 and rf_txen=1 -> snk_strobe pulses twice with snk_iq=0xF00100 then 0x002001; dac_locked=1 from the second word.
- While locked, repeat iqsel=1 twice -> sync_err_count 0->1, dac_locked=0, no strobe. Resume clean alternation -> relock on the next 0->1 edge and the next pair strobes correctly.
- Force 300 lock losses -> sync_err_count saturates at 255.
- Assert reset mid-pair on both sides -> the next clock shows all outputs 0 and an empty FIFO; no strobe is emitted for the partial sample.
- Loopback adc_data/adc_iqsel into dac_data/dac_iqsel -> snk_iq reproduces the src_iq sequence; the first strobe comes 3 clocks after the first I word.
